// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: orders two single-precision operands and aligns the smaller significand for the adder
module shift_right (
  input  logic [24:0] d_i,
  input  logic [4:0]  sh_i,
  output logic [24:0] q_o,
  output logic        sticky_o
);
  assign q_o      = {d_i[24], d_i[23:0] >> sh_i};
  // shifts of 24 or more leave the mask all ones, so every magnitude bit feeds sticky
  assign sticky_o = |(d_i[23:0] & ~(24'hFF_FFFF << sh_i));
endmodule

module fp_align_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] big_sig,
  output logic [24:0] small_sig,
  output logic [7:0]  exp_out,
  output logic        sticky,
  output logic        swapped,
  output logic        special
);
  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;
  state_t      state_q;
  logic [31:0] a_q, b_q;
  logic [24:0] big_q, small_q, ssig_q, sh_out;
  logic [7:0]  exp_q;
  logic [4:0]  nsh_q;
  logic        sticky_q, swapped_q, special_q, out_valid_q, sh_sticky;
  logic [7:0]  ea, eb, diff_d, exp_d;
  logic [24:0] sig_a, sig_b;
  logic        swap_d;
  logic [4:0]  nsh_d;
  assign ea     = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
  assign eb     = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
  assign sig_a  = {a_q[31], |a_q[30:23], a_q[22:0]};
  assign sig_b  = {b_q[31], |b_q[30:23], b_q[22:0]};
  // ties in both exponent and magnitude keep A as the larger operand
  assign swap_d = (eb > ea) | ((eb == ea) & (sig_b[23:0] > sig_a[23:0]));
  assign exp_d  = swap_d ? eb : ea;
  assign diff_d = swap_d ? eb - ea : ea - eb;
  assign nsh_d  = (diff_d > 8'd31) ? 5'd31 : diff_d[4:0];
  shift_right u_shift (
    .d_i     (ssig_q),
    .sh_i    (nsh_q),
    .q_o     (sh_out),
    .sticky_o(sh_sticky)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      big_q       <= '0;
      small_q     <= '0;
      ssig_q      <= '0;
      exp_q       <= '0;
      nsh_q       <= '0;
      sticky_q    <= 1'b0;
      swapped_q   <= 1'b0;
      special_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          state_q <= CMP;
        end
        CMP: begin
          swapped_q <= swap_d;
          big_q     <= swap_d ? sig_b : sig_a;
          ssig_q    <= swap_d ? sig_a : sig_b;
          exp_q     <= exp_d;
          nsh_q     <= nsh_d;
          special_q <= (&a_q[30:23]) | (&b_q[30:23]);
          state_q   <= SHIFT;
        end
        SHIFT: begin
          small_q     <= sh_out;
          sticky_q    <= sh_sticky;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign big_sig   = big_q;
  assign small_sig = small_q;
  assign exp_out   = exp_q;
  assign sticky    = sticky_q;
  assign swapped   = swapped_q;
  assign special   = special_q;
endmodule

// File: tb/tb_fp_align_ctrl.sv
// tb_fp_align_ctrl: directed checks of ordering, alignment, sticky, backpressure and reset abort
module tb_fp_align_ctrl;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, sticky, swapped, special;
  logic [24:0] big_sig, small_sig;
  logic [7:0]  exp_out;
  int          n_assert = 0, n_fail = 0;

  fp_align_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .big_sig(big_sig), .small_sig(small_sig),
    .exp_out(exp_out), .sticky(sticky), .swapped(swapped), .special(special)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":out_valid"}, out_valid, 0);
    chk({tag, ":big"}, big_sig, 0);
    chk({tag, ":small"}, small_sig, 0);
    chk({tag, ":exp"}, exp_out, 0);
    chk({tag, ":flags"}, {sticky, swapped, special}, 0);
  endtask

  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] e_big, input logic [31:0] e_small, input logic [31:0] e_exp,
                       input logic e_st, input logic e_sw, input logic e_sp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    chk({tag, ":ready"}, in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick; n++; end
    chk({tag, ":latency"}, n, 2);
    chk({tag, ":big"}, big_sig, e_big);
    chk({tag, ":small"}, small_sig, e_small);
    chk({tag, ":exp"}, exp_out, e_exp);
    chk({tag, ":sticky"}, sticky, e_st);
    chk({tag, ":swapped"}, swapped, e_sw);
    chk({tag, ":special"}, special, e_sp);
    if (out_ready) begin
      tick;
      chk({tag, ":post_valid"}, out_valid, 0);
      chk({tag, ":post_ready"}, in_ready, 1);
    end
  endtask

  initial begin
    tick; tick;
    chk("rst:in_ready", in_ready, 0);
    chk_zero("rst");
    rst = 1'b0;
    tick;
    chk("rst_rel:in_ready", in_ready, 1);

    do_op("t1", 32'h3F800000, 32'h3F000000, 32'h0800000, 32'h0400000, 32'h7F, 0, 0, 0);
    do_op("t2", 32'h3F000000, 32'hC0000000, 32'h1800000, 32'h0200000, 32'h80, 0, 1, 0);
    do_op("eq_exp", 32'h3F800000, 32'h3FC00000, 32'h0C00000, 32'h0800000, 32'h7F, 0, 1, 0);
    do_op("tie", 32'h3F800000, 32'h3F800000, 32'h0800000, 32'h0800000, 32'h7F, 0, 0, 0);
    do_op("diff24", 32'h4B800000, 32'h3F800001, 32'h0800000, 32'h0000000, 32'h97, 1, 0, 0);
    do_op("clamp31", 32'h7F000000, 32'h00000001, 32'h0800000, 32'h0000000, 32'hFE, 1, 0, 0);
    do_op("neg_small", 32'h40000000, 32'hBF800000, 32'h0800000, 32'h1400000, 32'h80, 0, 0, 0);
    do_op("part_sticky", 32'h40000000, 32'h3F800003, 32'h0800000, 32'h0400001, 32'h80, 1, 0, 0);
    do_op("special", 32'h7F800000, 32'h3F800000, 32'h0800000, 32'h0000000, 32'hFF, 1, 0, 1);

    out_ready = 1'b0;
    do_op("bp", 32'h40400000, 32'h3F800000, 32'h0C00000, 32'h0400000, 32'h80, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 32'h3F800000; b = 32'h3F000000; in_valid = 1'b1;
      end
      tick;
      in_valid = 1'b0;
      chk("bp:hold_valid", out_valid, 1);
      chk("bp:hold_ready", in_ready, 0);
      chk("bp:hold_big", big_sig, 32'h0C00000);
      chk("bp:hold_small", small_sig, 32'h0400000);
      chk("bp:hold_exp", exp_out, 32'h80);
    end
    out_ready = 1'b1;
    tick;
    chk("bp:release_valid", out_valid, 0);
    chk("bp:release_ready", in_ready, 1);
    do_op("bp_next", 32'h40000000, 32'h3F800003, 32'h0800000, 32'h0400001, 32'h80, 1, 0, 0);

    a = 32'h3F000000; b = 32'hC0000000; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    chk("abort:pre_valid", out_valid, 0);
    rst = 1'b1;
    tick;
    chk("abort:in_ready", in_ready, 0);
    chk_zero("abort");
    rst = 1'b0;
    tick;
    chk("abort:rel_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("abort:no_result", out_valid, 0);
    end

    rst = 1'b1; in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F000000;
    tick;
    chk("rst_vs_valid:in_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick; tick; tick; tick;
    chk("rst_vs_valid:no_result", out_valid, 0);
    chk("rst_vs_valid:ready", in_ready, 1);

    do_op("recover", 32'h3F800000, 32'h3F000000, 32'h0800000, 32'h0400000, 32'h7F, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
